// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Asynchronous-serial transmitter driven by a once-per-bit-period clock enable
// (baud_tick) from the CLOCK_50 baud divider. Each accepted byte is sent as:
// one start bit (0), DATA_BITS data bits LSB first, an optional parity bit, and
// STOP_BITS stop bits (1). The line idles high and is driven from a register.
//
// Parameters
//   DATA_BITS  data bits per frame, 5..8
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  1 or 2
//
// Ports
//   CLOCK_50    single clock, rising edge
//   reset       synchronous, active-low
//   baud_tick   one-cycle pulse per bit period (clock enable, not a clock)
//   tx_data     byte to send, sampled only on the acceptance cycle
//   tx_valid    upstream has a byte
//   tx_ready    block can accept (high only in IDLE)
//   tx          serial line, idle high
//   busy        high from acceptance until the frame completes
//   frame_done  one-cycle pulse when the last stop bit ends
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [2:0] LAST_BIT    = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP   = 1'(STOP_BITS - 1);
  localparam bit         HAS_PARITY  = (PARITY != 0);
  localparam logic       ODD_PARITY  = (PARITY == 1);

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 frame_done_q, frame_done_d;

  // Next-state and next-output logic. Outputs are registered, so the value
  // assigned to tx_d here appears on the line one cycle after the tick.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    parity_d     = parity_q;
    tx_d         = tx_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        // Ticks are deliberately ignored here; the frame is anchored to the
        // first tick after acceptance, which is what ARM waits for.
        if (tx_valid) begin
          shift_d  = tx_data;
          parity_d = (^tx_data) ^ ODD_PARITY;
          state_d  = S_ARM;
        end
      end

      S_ARM: begin
        if (baud_tick) begin
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end

      S_START: begin
        if (baud_tick) begin
          state_d   = S_DATA;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = 3'd0;
        end
      end

      S_DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            // Counter holds at LAST_BIT rather than wrapping.
            if (HAS_PARITY) begin
              state_d = S_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d    = S_STOP;
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end

      S_PARITY: begin
        if (baud_tick) begin
          state_d    = S_STOP;
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end

      S_STOP: begin
        tx_d = 1'b1;
        if (baud_tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            state_d      = S_IDLE;
            stop_cnt_d   = 1'b0;
            frame_done_d = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (!reset) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= 3'd0;
      stop_cnt_q   <= 1'b0;
      parity_q     <= 1'b0;
      tx_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      parity_q     <= parity_d;
      tx_q         <= tx_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Handshake and status come straight from registered state, so tx_ready
  // never depends combinationally on tx_valid.
  assign tx_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign tx         = tx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Four serializer instances (8N1, 8E1, 8O1, 7N2) share clock, reset and a
// free-running baud_tick. Expected frames are built from the byte and the
// instance configuration and queued when a byte is offered; a receiver task
// pops them and compares the line bit by bit (first and last cycle of every
// bit period), then checks the frame_done pulse and busy.
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

  localparam int P     = 218;  // clock cycles per bit period
  localparam int N_DUT = 4;

  typedef struct {
    int          idx;
    logic [15:0] bits;
    int          nbits;
  } frame_t;

  logic             CLOCK_50 = 1'b0;
  logic             reset;
  logic             baud_tick;
  logic [7:0]       tx_data_v [N_DUT];
  logic [N_DUT-1:0] tx_valid_v;
  logic [N_DUT-1:0] ready_v;
  logic [N_DUT-1:0] tx_v;
  logic [N_DUT-1:0] busy_v;
  logic [N_DUT-1:0] fd_v;

  int dbits_c  [N_DUT] = '{8, 8, 8, 7};
  int par_c    [N_DUT] = '{0, 2, 1, 0};
  int stop_c   [N_DUT] = '{1, 1, 1, 2};

  int fd_cnt   [N_DUT] = '{default: 0};
  int acc_cnt  [N_DUT] = '{default: 0};
  int cyc      = 0;
  int tick_cnt = 0;
  int checks   = 0;
  int errors   = 0;

  frame_t sb[$];

  always #5 CLOCK_50 = ~CLOCK_50;

  uart_tx_serializer u_8n1 (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .baud_tick (baud_tick),
    .tx_data   (tx_data_v[0]),
    .tx_valid  (tx_valid_v[0]),
    .tx_ready  (ready_v[0]),
    .tx        (tx_v[0]),
    .busy      (busy_v[0]),
    .frame_done(fd_v[0])
  );

  uart_tx_serializer #(.PARITY(2)) u_8e1 (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .baud_tick (baud_tick),
    .tx_data   (tx_data_v[1]),
    .tx_valid  (tx_valid_v[1]),
    .tx_ready  (ready_v[1]),
    .tx        (tx_v[1]),
    .busy      (busy_v[1]),
    .frame_done(fd_v[1])
  );

  uart_tx_serializer #(.PARITY(1)) u_8o1 (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .baud_tick (baud_tick),
    .tx_data   (tx_data_v[2]),
    .tx_valid  (tx_valid_v[2]),
    .tx_ready  (ready_v[2]),
    .tx        (tx_v[2]),
    .busy      (busy_v[2]),
    .frame_done(fd_v[2])
  );

  uart_tx_serializer #(.DATA_BITS(7), .STOP_BITS(2)) u_7n2 (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .baud_tick (baud_tick),
    .tx_data   (tx_data_v[3][6:0]),
    .tx_valid  (tx_valid_v[3]),
    .tx_ready  (ready_v[3]),
    .tx        (tx_v[3]),
    .busy      (busy_v[3]),
    .frame_done(fd_v[3])
  );

  // Free-running divider model: one-cycle tick every P cycles, changed on the
  // falling edge so it is stable at the sampling edge.
  initial begin
    baud_tick = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      tick_cnt++;
      baud_tick = ((tick_cnt % P) == 0);
    end
  end

  // Cycle counter plus per-instance counts of frame_done pulses and transfers.
  always @(posedge CLOCK_50) begin
    cyc <= cyc + 1;
    for (int i = 0; i < N_DUT; i++) begin
      if (fd_v[i] === 1'b1) fd_cnt[i] <= fd_cnt[i] + 1;
      if (tx_valid_v[i] && ready_v[i]) acc_cnt[i] <= acc_cnt[i] + 1;
    end
  end

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic frame_t make_frame(input int idx, input logic [7:0] d);
    frame_t f;
    logic   p;
    f.idx   = idx;
    f.bits  = '0;
    f.nbits = 1;              // bit 0 is the start bit, left at 0
    p       = 1'b0;
    for (int i = 0; i < dbits_c[idx]; i++) begin
      f.bits[f.nbits] = d[i];
      p ^= d[i];
      f.nbits++;
    end
    if (par_c[idx] != 0) begin
      f.bits[f.nbits] = (par_c[idx] == 1) ? ~p : p;
      f.nbits++;
    end
    for (int i = 0; i < stop_c[idx]; i++) begin
      f.bits[f.nbits] = 1'b1;
      f.nbits++;
    end
    return f;
  endfunction

  // Offer a byte, wait for the transfer, then scramble tx_data.
  task automatic send(input int idx, input logic [7:0] d, input bit hold, input bit push);
    int w;
    @(negedge CLOCK_50);
    tx_data_v[idx]  = d;
    tx_valid_v[idx] = 1'b1;
    if (push) sb.push_back(make_frame(idx, d));
    w = 0;
    while (ready_v[idx] !== 1'b1 && w < 4 * P) begin
      @(negedge CLOCK_50);
      w++;
    end
    @(negedge CLOCK_50);
    check($sformatf("dut%0d_accept_busy_ready", idx), 32'({busy_v[idx], ready_v[idx]}), 32'h2);
    tx_data_v[idx] = ~d;
    if (!hold) tx_valid_v[idx] = 1'b0;
  endtask

  // Wait for a start bit, pop the expected frame and compare it bit by bit.
  task automatic receive(input int idx, input bit mid_en, input logic [7:0] mid_d,
                         input bit drop, output int t0);
    frame_t f;
    int     w;
    int     fd0;
    logic   first_s;
    t0      = -1;
    first_s = 1'b0;
    w       = 0;
    while (tx_v[idx] !== 1'b0 && w < 4 * P) begin
      @(negedge CLOCK_50);
      w++;
    end
    if (tx_v[idx] !== 1'b0) begin
      check($sformatf("dut%0d_start_seen", idx), 32'(tx_v[idx]), 32'h0);
      return;
    end
    t0 = cyc;
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 32'(sb.size()), 32'h1);
      return;
    end
    f   = sb.pop_front();
    fd0 = fd_cnt[idx];
    for (int k = 0; k < f.nbits * P; k++) begin
      if (k > 0) @(negedge CLOCK_50);
      if (mid_en && k == 4 * P) tx_data_v[idx] = mid_d;
      if ((k % P) == 0) first_s = tx_v[idx];
      if ((k % P) == P - 1)
        check($sformatf("dut%0d_bit%0d", idx, k / P), 32'({first_s, tx_v[idx]}),
              32'({f.bits[k / P], f.bits[k / P]}));
    end
    @(negedge CLOCK_50);
    check($sformatf("dut%0d_done_busy", idx), 32'({fd_v[idx], busy_v[idx]}), 32'h2);
    check($sformatf("dut%0d_no_early_done", idx), 32'(fd_cnt[idx] - fd0), 32'h0);
    if (drop) tx_valid_v[idx] = 1'b0;
    @(negedge CLOCK_50);
    check($sformatf("dut%0d_done_single", idx), 32'({fd_v[idx], 31'(fd_cnt[idx] - fd0)}), 32'h1);
  endtask

  initial begin
    int t1, t2, n_acc, a0, fd0, w;

    reset      = 1'b0;
    tx_valid_v = '0;
    for (int i = 0; i < N_DUT; i++) tx_data_v[i] = '0;

    // Reset values on every instance.
    repeat (3) @(negedge CLOCK_50);
    check("reset_tx",    32'(tx_v),    32'hF);
    check("reset_ready", 32'(ready_v), 32'hF);
    check("reset_busy",  32'(busy_v),  32'h0);
    check("reset_done",  32'(fd_v),    32'h0);
    reset = 1'b1;

    // Ticks while idle change nothing.
    repeat (2 * P) @(negedge CLOCK_50);
    check("idle_ticks_ignored", 32'({tx_v[0], ready_v[0], busy_v[0], fd_v[0]}), 32'hC);

    // 8N1, 0xA5.
    send(0, 8'hA5, 1'b0, 1'b1);
    receive(0, 1'b0, 8'h00, 1'b1, t1);

    // Parity variants.
    send(1, 8'hA5, 1'b0, 1'b1);
    receive(1, 1'b0, 8'h00, 1'b1, t1);
    send(2, 8'hA5, 1'b0, 1'b1);
    receive(2, 1'b0, 8'h00, 1'b1, t1);
    send(2, 8'h01, 1'b0, 1'b1);
    receive(2, 1'b0, 8'h00, 1'b1, t1);

    // 7 data bits, 2 stop bits, 0x7F: ten tick periods in all.
    send(3, 8'h7F, 1'b0, 1'b1);
    receive(3, 1'b0, 8'h00, 1'b1, t1);

    // Back-to-back with tx_valid held and tx_data changed mid-frame.
    a0 = acc_cnt[0];
    send(0, 8'h55, 1'b1, 1'b1);
    sb.push_back(make_frame(0, 8'h0F));
    receive(0, 1'b1, 8'h0F, 1'b0, t1);
    receive(0, 1'b1, 8'h33, 1'b1, t2);
    check("b2b_arm_gap", 32'(t2 - t1), 32'(11 * P));
    repeat (4) @(negedge CLOCK_50);
    check("b2b_accept_count", 32'(acc_cnt[0] - a0), 32'h2);

    // Offer a byte on the same cycle as a tick: the start waits a full period.
    w = 0;
    do begin
      @(negedge CLOCK_50);
      #1;
      w++;
    end while (baud_tick !== 1'b1 && w < 2 * P);
    tx_data_v[0]  = 8'h3C;
    tx_valid_v[0] = 1'b1;
    sb.push_back(make_frame(0, 8'h3C));
    n_acc = cyc;
    @(negedge CLOCK_50);
    check("coincide_busy_ready", 32'({busy_v[0], ready_v[0]}), 32'h2);
    tx_valid_v[0] = 1'b0;
    tx_data_v[0]  = 8'hFF;
    receive(0, 1'b0, 8'h00, 1'b1, t1);
    check("coincide_start_cycle", 32'(t1), 32'(n_acc + P + 1));

    // Reset in the middle of a frame abandons it.
    fd0 = fd_cnt[0];
    send(0, 8'h00, 1'b0, 1'b0);
    w = 0;
    while (tx_v[0] !== 1'b0 && w < 4 * P) begin
      @(negedge CLOCK_50);
      w++;
    end
    repeat (P + 5) @(negedge CLOCK_50);
    check("pre_reset_line_low", 32'(tx_v[0]), 32'h0);
    reset = 1'b0;
    @(negedge CLOCK_50);
    check("midframe_reset_state", 32'({tx_v[0], ready_v[0], busy_v[0], fd_v[0]}), 32'hC);
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b1;
    repeat (3 * P) @(negedge CLOCK_50);
    check("post_reset_idle", 32'({tx_v[0], ready_v[0], busy_v[0]}), 32'h6);
    check("post_reset_no_done", 32'(fd_cnt[0] - fd0), 32'h0);

    // A clean frame after the abandoned one.
    send(0, 8'hC3, 1'b0, 1'b1);
    receive(0, 1'b0, 8'h00, 1'b1, t1);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Serial transmitter that sits directly downstream of the CLOCK_50 baud-rate divider. It consumes the divider's once-per-bit-period pulse as `baud_tick` and serialises parallel bytes onto an asynchronous serial line. The frame is a start bit, data bits sent LSB first, optional parity, and 1 or 2 stop bits. Upstream logic loads bytes through a valid/ready handshake. Everything runs in the CLOCK_50 domain; `baud_tick` is a clock enable, not a clock.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5–8.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.
- `CLOCK_50` input, 1 bit: the single clock; all logic on its rising edge.
- `reset` input, 1 bit: synchronous, active-low. Sampled on the CLOCK_50 rising edge; 0 resets.
- `baud_tick` input, 1 bit: one-cycle pulse, once per bit period, from the divider.
- `tx_data` input, `DATA_BITS` wide: byte to send; sampled on the acceptance cycle only.
- `tx_valid` input, 1 bit: upstream has data.
- `tx_ready` output, 1 bit: block can accept. A transfer occurs on any cycle with `tx_valid` && `tx_ready`.
- `tx` output, 1 bit: serial line, idle high, registered.
- `busy` output, 1 bit: high from the acceptance cycle until the frame completes.
- `frame_done` output, 1 bit: one-cycle pulse when the last stop bit ends.

## Operation
- FSM states: IDLE, ARM, START, DATA, PARITY, STOP.
- IDLE
  - `tx_ready`=1, `tx`=1.
  - On acceptance, latch `tx_data` into the shift register, compute the parity bit, and go to ARM.
- ARM
  - Wait for the next `baud_tick`; on it go to START and drive `tx`=0.
- START
  - On `baud_tick`, go to DATA and drive shift[0]; bit counter = 0.
- DATA
  - On each `baud_tick`, shift right and increment the counter.
  - After bit `DATA_BITS`-1 completes, go to PARITY if `PARITY`≠0, else to STOP.
- PARITY
  - Drives XOR of the data bits: inverted for odd parity, plain for even.
  - On `baud_tick`, go to STOP.
- STOP
  - `tx`=1 for `STOP_BITS` tick periods.
  - On the tick that ends the last stop bit, pulse `frame_done` and return to IDLE.
- Shift-register width is `DATA_BITS`. The bit counter is 3 bits and saturates at `DATA_BITS`-1, with no wrap past it. Stop counter is 1 bit.
- `tx_ready` = (state==IDLE). It is combinational from registered state and never depends on `tx_valid`.
- `tx_data` changes after acceptance have no effect on the frame in flight.
- `tx_valid` is ignored while not IDLE; no byte is lost or duplicated.
- A `baud_tick` while in IDLE is ignored.

## Timing
- Reset values: state=IDLE, `tx`=1, `tx_ready`=1, `busy`=0, `frame_done`=0, counters=0. All take effect the cycle after `reset` is sampled low.
- Reset mid-frame abandons the frame. `tx` returns to 1 on the next edge, and no `frame_done` is issued.
- Acceptance on cycle N:
  - `busy`=1 and `tx_ready`=0 from N+1.
  - The start bit begins the cycle after the first `baud_tick` strictly after N.
- Acceptance coinciding with `baud_tick`: that tick does not start the frame; the next one does.
- Bit timing: every bit, including the start bit, lasts exactly one tick period. Bit boundaries fall one cycle after each tick (registered output).
- Frame length in tick periods is 1 + `DATA_BITS` + (`PARITY`≠0) + `STOP_BITS`.
- `frame_done` and the `busy` fall occur on the same edge as the return to IDLE.
- Back-to-back: `tx_valid` held high is accepted the cycle after `frame_done`. This gives at least one extra high period (ARM) between frames.
- `baud_tick` spacing must be ≥2 cycles. Pulses longer than one cycle count once per cycle high; this is a caller error.

## Test plan
- Reset: hold `reset`=0 for 3 cycles mid-frame -> `tx`=1, `tx_ready`=1, `busy`=0 on the next edge, and no `frame_done`.
- Defaults (8N1), send 0xA5, ticks every 218 cycles -> `tx` shows 0, 1,0,1,0,0,1,0,1, 1, each bit 218 cycles, then one `frame_done` pulse.
- `PARITY`=2, send 0xA5 -> parity bit 0. `PARITY`=1, send 0xA5 -> parity bit 1. `PARITY`=1, send 0x01 -> parity bit 0.
- `STOP_BITS`=2, `DATA_BITS`=7, send 0x7F -> 7 ones after the start bit, then 2 stop-bit periods high; total 10 tick periods.
- Hold `tx_valid`=1 with 0x55 then 0x0F, and toggle `tx_data` mid-frame -> both frames are exact and in order. A single acceptance per frame, with one ARM gap between them.
- `tx_valid` asserted on the same cycle as `baud_tick` in IDLE -> accepted, and the start bit is delayed to the next tick.
